bus_master_if: RTL and testbench

- Initiator-side engine that converts a simple command/response stream into two-phase (setup/access) transactions on the master port of the 4-slave NIC address router.
- Sits between a client (CPU stub, DMA, test driver) and the NIC master port.
- Owns bus sequencing: sel/enable phasing, wr_dir, address and data hold, and read-latency alignment. Returns exactly one response per command.

---
 rtl/bus_pkg.sv | 15 +
 rtl/bus_master_if.sv | 97 +++++++++
 tb/tb_bus_master_if.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, slave-select field position and default widths
package bus_pkg;
    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 16;
    localparam int SLAVE_SEL_MSB = 15;
    localparam int SLAVE_SEL_LSB = 14;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;
endpackage

// File: rtl/bus_master_if.sv
// bus_master_if: turns one command into a setup/access bus transaction and returns one response
//   client side : cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_wdata in, rsp_valid/rsp_ready/rsp_wr/rsp_rdata out, busy
//   bus side    : master_sel/master_enable/master_wr_dir/master_addr/master_wdata out, master_rdata in
module bus_master_if
    import bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              master_sel,
    output logic              master_enable,
    output logic              master_wr_dir,
    output logic [ADDR_W-1:0] master_addr,
    output logic [DATA_W-1:0] master_wdata,
    input  logic [DATA_W-1:0] master_rdata
);
    state_t     state;
    logic [3:0] cnt;
    logic       op_wr;

    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            op_wr         <= 1'b0;
            master_sel    <= 1'b0;
            master_enable <= 1'b0;
            master_wr_dir <= 1'b0;
            master_addr   <= '0;
            master_wdata  <= '0;
            rsp_valid     <= 1'b0;
            rsp_wr        <= 1'b0;
            rsp_rdata     <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    master_sel    <= 1'b1;
                    master_enable <= 1'b0;
                    master_wr_dir <= cmd_wr;
                    master_addr   <= cmd_addr;
                    if (cmd_wr) master_wdata <= cmd_wdata;
                    op_wr         <= cmd_wr;
                    state         <= SETUP;
                end
                SETUP: begin
                    master_enable <= 1'b1;
                    state         <= ACCESS;
                end
                ACCESS: if (op_wr) begin
                    master_sel    <= 1'b0;
                    master_enable <= 1'b0;
                    master_wr_dir <= 1'b0;
                    rsp_valid     <= 1'b1;
                    rsp_wr        <= 1'b1;
                    rsp_rdata     <= '0;
                    state         <= RESP;
                end else begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                // master_addr stays live here: the NIC steers read data back by its slave field
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(RD_WAIT - 1)) begin
                        rsp_rdata     <= master_rdata;
                        rsp_wr        <= 1'b0;
                        rsp_valid     <= 1'b1;
                        master_sel    <= 1'b0;
                        master_enable <= 1'b0;
                        state         <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: directed stimulus, slave stub with three register stages, cycle-level reference model
module tb_bus_master_if;
    localparam int RD_WAIT = 2;

    logic        clk = 0, rst_n = 0;
    logic        cmd_valid = 0, cmd_wr = 0, rsp_ready = 1;
    logic [15:0] cmd_addr = 0, cmd_wdata = 0;
    logic        cmd_ready, rsp_valid, rsp_wr, busy;
    logic [15:0] rsp_rdata;
    logic        m_sel, m_en, m_wdir;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] m_rdata = 0;

    int total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_master_if #(.ADDR_W(16), .DATA_W(16), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
        .busy(busy),
        .master_sel(m_sel), .master_enable(m_en), .master_wr_dir(m_wdir),
        .master_addr(m_addr), .master_wdata(m_wdata), .master_rdata(m_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Slave stand-in: address register, memory register, return register
    logic [15:0] smem [0:65535];
    logic [15:0] p1 = 0, p2 = 0;
    always @(posedge clk) begin
        if (m_sel && m_en && m_wdir) smem[m_addr] <= m_wdata;
        p1      <= m_addr;
        p2      <= smem[p1];
        m_rdata <= p2;
    end

    // Reference model: cycles elapsed since the accept edge decide every output
    logic [15:0] mm [0:65535];
    logic        mb = 0, mrv = 0, mrwr = 0, mop = 0;
    logic [15:0] mrd = 0, maddr = 0, mwd = 0;
    int          age = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb = 0; mrv = 0; mrwr = 0; mop = 0; mrd = 0; maddr = 0; mwd = 0; age = 0;
        end else if (!mb) begin
            if (cmd_valid) begin
                mb = 1; age = 0; mop = cmd_wr; maddr = cmd_addr;
                if (cmd_wr) begin
                    mwd = cmd_wdata;
                    mm[cmd_addr] = cmd_wdata;
                end
            end
        end else if (mrv) begin
            if (rsp_ready) begin
                mrv = 0; mb = 0;
            end
        end else begin
            age++;
            if (age == (mop ? 2 : 2 + RD_WAIT)) begin
                mrv = 1; mrwr = mop; mrd = mop ? 16'h0 : mm[maddr];
            end
        end
    end

    always @(negedge clk) begin
        chk("cmd_ready", cmd_ready, !mb);
        chk("busy", busy, mb);
        chk("master_sel", m_sel, mb && !mrv);
        chk("master_enable", m_en, mb && !mrv && age >= 1);
        chk("master_wr_dir", m_wdir, mb && !mrv && mop);
        chk("master_addr", m_addr, maddr);
        chk("master_wdata", m_wdata, mwd);
        chk("rsp_valid", rsp_valid, mrv);
        chk("rsp_wr", rsp_wr, mrwr);
        chk("rsp_rdata", rsp_rdata, mrd);
    end

    int          acc_q[$];
    logic [15:0] rq[$];
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (rsp_valid && rsp_ready) rq.push_back(rsp_rdata);
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, output int acc);
        int n;
        cmd_wr = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1; n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
        acc = cyc;
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic run(input logic w, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output logic rw, output int lat);
        int acc, n;
        issue(w, a, d, acc);
        wait_rv(n);
        lat = cyc - acc; rd = rsp_rdata; rw = rsp_wr;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] rd;
        logic        rw;
        int          lat, acc, n;
        logic [15:0] wa [4];
        logic [15:0] wd [4];
        wa = '{16'h0001, 16'h4001, 16'h8001, 16'hC001};
        wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_sel", m_sel, 0);
        @(posedge clk); #1;

        run(1, 16'h4005, 16'hBEEF, rd, rw, lat);
        chk("wr_rsp_wr", rw, 1);
        chk("wr_rsp_rdata", rd, 16'h0000);
        chk("wr_latency", lat, 2);
        run(0, 16'h4005, 16'h0000, rd, rw, lat);
        chk("rd_rsp_wr", rw, 0);
        chk("rd_rsp_rdata", rd, 16'hBEEF);
        chk("rd_capture_edge", lat, 4);

        for (int i = 0; i < 4; i++) run(1, wa[i], wd[i], rd, rw, lat);
        for (int i = 0; i < 4; i++) begin
            run(0, wa[i], 16'h0000, rd, rw, lat);
            chk("slave_readback", rd, wd[i]);
        end

        issue(1, 16'h3FFF, 16'hA5A5, acc);
        @(negedge clk);
        chk("ph_setup_sel", m_sel, 1);
        chk("ph_setup_en", m_en, 0);
        @(negedge clk);
        chk("ph_access_sel", m_sel, 1);
        chk("ph_access_en", m_en, 1);
        chk("ph_access_valid", rsp_valid, 0);
        @(negedge clk);
        chk("ph_done_sel", m_sel, 0);
        chk("ph_done_valid", rsp_valid, 1);
        chk("ph_done_rdata", rsp_rdata, 16'h0000);
        chk("ph_wdata", m_wdata, 16'hA5A5);
        @(posedge clk); #1;

        rsp_ready = 0;
        issue(0, 16'h8001, 16'h0000, acc);
        wait_rv(n);
        @(posedge clk); #1;
        cmd_wr = 1; cmd_addr = 16'h0001; cmd_wdata = 16'hFFFF; cmd_valid = 1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 16'h3333);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk); #1;
        cmd_valid = 0; rsp_ready = 1;
        @(negedge clk);
        chk("bp_release_valid", rsp_valid, 1);
        @(negedge clk);
        chk("bp_idle", cmd_ready, 1);
        chk("bp_valid_low", rsp_valid, 0);
        @(posedge clk); #1;
        run(0, 16'h0001, 16'h0000, rd, rw, lat);
        chk("bp_not_accepted", rd, 16'h1111);

        acc_q.delete(); rq.delete();
        issue(0, 16'h0001, 16'h0000, acc);
        issue(0, 16'h4001, 16'h0000, acc);
        issue(0, 16'hC001, 16'h0000, acc);
        n = 0;
        while (rq.size() < 3 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_count", rq.size(), 3);
        chk("b2b_acc_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk("b2b_gap1", acc_q[1] - acc_q[0], 4 + RD_WAIT);
            chk("b2b_gap2", acc_q[2] - acc_q[1], 4 + RD_WAIT);
        end
        if (rq.size() == 3) begin
            chk("b2b_rsp0", rq[0], 16'h1111);
            chk("b2b_rsp1", rq[1], 16'h2222);
            chk("b2b_rsp2", rq[2], 16'h4444);
        end
        @(posedge clk); #1;

        issue(0, 16'h4005, 16'h0000, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_busy", busy, 1);
        rst_n = 0;
        @(negedge clk);
        chk("rst_mid_sel", m_sel, 0);
        chk("rst_mid_en", m_en, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        chk("rst_mid_addr", m_addr, 16'h0000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (8) begin
            @(negedge clk);
            chk("rst_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;
        run(0, 16'hC001, 16'h0000, rd, rw, lat);
        chk("post_rst_read", rd, 16'h4444);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end
endmodule
